// File: rtl/snes_region_ctrl.sv
// Region controller: CSYNC line-count video standard detection, colour-carrier divider, B-bus region patch.
// Optional macro SNES_REGION_LINECNT_EN adds LINE_COUNT_o and FRAME_TICK_o.
module snes_region_ctrl #(
  parameter int NUM_PATCH_REGS = 1,
  parameter logic [8*NUM_PATCH_REGS-1:0] PATCH_ADDR_LIST = 8'h3f,
  parameter int HSYNC_MIN_CLKS = 1000,
  parameter int VSYNC_PULSE_CLKS = 400,
  parameter int LINES_PAL_MIN = 287,
  parameter int STABLE_FRAMES = 3,
  parameter int CC_HALF_NTSC = 3,
  parameter int CC_HALF_PAL = 2,
  parameter int TIMEOUT_LOG2 = 21
) (
  input  logic                      MCLK_i,
  input  logic                      RESET_i,
  input  logic                      CSYNC_i,
  input  logic [1:0]                FORCE_MODE_i,
  input  logic                      NPARD_i,
  input  logic [7:0]                ADDRESS_BUS_B_i,
  input  logic                      EN_REGPATCH_i,
  output logic [NUM_PATCH_REGS-1:0] NDRIVE_o,
  output logic                      PALMODE_o,
  output logic [1:0]                NPALMODE_o,
  output logic                      MODE_VALID_o,
  output logic                      ColorCarrier_o
`ifdef SNES_REGION_LINECNT_EN
  ,
  output logic [9:0]                LINE_COUNT_o,
  output logic                      FRAME_TICK_o
`endif
);

  localparam int LW_W   = $clog2(VSYNC_PULSE_CLKS + 1);
  localparam int CC_MAX = (CC_HALF_NTSC > CC_HALF_PAL) ? CC_HALF_NTSC : CC_HALF_PAL;
  localparam int CC_W   = (CC_MAX > 1) ? $clog2(CC_MAX) : 1;

  logic                    csync_meta, csync_sync, csync_prev;
  logic [LW_W-1:0]         low_cnt;
  logic [9:0]              gap_cnt, line_cnt;
  logic                    armed;
  logic [TIMEOUT_LOG2-1:0] to_cnt;
  logic                    cand, auto_pal;
  logic [3:0]              stable_cnt;
  logic [CC_W-1:0]         cc_cnt, half_m1;
  logic                    pal_d;

  logic       fall, counted, boundary, verdict, timeout, cand_next;
  logic [3:0] stable_next;

  always_comb begin
    fall     = csync_prev & ~csync_sync;
    counted  = fall && (gap_cnt >= 10'(HSYNC_MIN_CLKS));
    boundary = armed && (low_cnt == LW_W'(VSYNC_PULSE_CLKS));
    verdict  = (line_cnt >= 10'(LINES_PAL_MIN));
    timeout  = &to_cnt;
    half_m1  = PALMODE_o ? CC_W'(CC_HALF_PAL - 1) : CC_W'(CC_HALF_NTSC - 1);
    cand_next   = cand;
    stable_next = stable_cnt;
    if (verdict == cand) begin
      if (stable_cnt < 4'(STABLE_FRAMES)) stable_next = stable_cnt + 4'd1;
    end else begin
      cand_next   = verdict;
      stable_next = 4'd1;
    end
  end

  always_ff @(posedge MCLK_i) begin
    if (RESET_i) begin
      csync_meta     <= 1'b1;
      csync_sync     <= 1'b1;
      csync_prev     <= 1'b1;
      low_cnt        <= '0;
      gap_cnt        <= '0;
      line_cnt       <= '0;
      armed          <= 1'b0;
      to_cnt         <= '0;
      cand           <= 1'b0;
      auto_pal       <= 1'b0;
      stable_cnt     <= '0;
      MODE_VALID_o   <= 1'b0;
      PALMODE_o      <= 1'b0;
      pal_d          <= 1'b0;
      cc_cnt         <= '0;
      ColorCarrier_o <= 1'b0;
    end else begin
      csync_meta <= CSYNC_i;
      csync_sync <= csync_meta;
      csync_prev <= csync_sync;

      if (csync_sync) low_cnt <= '0;
      else if (low_cnt != LW_W'(VSYNC_PULSE_CLKS)) low_cnt <= low_cnt + 1'b1;

      if (counted) gap_cnt <= '0;
      else if (~&gap_cnt) gap_cnt <= gap_cnt + 1'b1;

      // only one boundary per field: re-armed by the next counted line edge
      if (counted) armed <= 1'b1;
      else if (boundary) armed <= 1'b0;

      if (boundary) line_cnt <= counted ? 10'd1 : 10'd0;
      else if (counted && ~&line_cnt) line_cnt <= line_cnt + 1'b1;

      if (boundary) begin
        to_cnt     <= '0;
        cand       <= cand_next;
        stable_cnt <= stable_next;
        if (stable_next == 4'(STABLE_FRAMES)) begin
          auto_pal     <= cand_next;
          MODE_VALID_o <= 1'b1;
        end
      end else begin
        to_cnt <= to_cnt + 1'b1;
        if (timeout) begin
          MODE_VALID_o <= 1'b0;
          stable_cnt   <= '0;
        end
      end

      case (FORCE_MODE_i)
        2'b00:   PALMODE_o <= auto_pal;
        2'b01:   PALMODE_o <= 1'b0;
        2'b10:   PALMODE_o <= 1'b1;
        default: PALMODE_o <= PALMODE_o;
      endcase

      // restart the divider after a mode change without touching the output level
      pal_d <= PALMODE_o;
      if (pal_d != PALMODE_o) begin
        cc_cnt <= '0;
      end else if (cc_cnt == half_m1) begin
        cc_cnt         <= '0;
        ColorCarrier_o <= ~ColorCarrier_o;
      end else begin
        cc_cnt <= cc_cnt + 1'b1;
      end
    end
  end

  assign NPALMODE_o = {2{~PALMODE_o}};

  always_comb begin
    for (int k = 0; k < NUM_PATCH_REGS; k++) begin
      NDRIVE_o[k] = ~(EN_REGPATCH_i & ~NPARD_i &
                      (ADDRESS_BUS_B_i == PATCH_ADDR_LIST[8*k +: 8]));
    end
  end

`ifdef SNES_REGION_LINECNT_EN
  always_ff @(posedge MCLK_i) begin
    if (RESET_i) begin
      LINE_COUNT_o <= '0;
      FRAME_TICK_o <= 1'b0;
    end else begin
      FRAME_TICK_o <= boundary;
      if (boundary) LINE_COUNT_o <= line_cnt;
    end
  end
`endif

endmodule
